// File: rtl/subr4u_pkg.sv
// rtl/subr4u_pkg.sv - shared types and constants for the bit-serial subtractor
package subr4u_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

endpackage

// File: rtl/subr4u_serial_fsub1.sv
// rtl/subr4u_serial_fsub1.sv - combinational 1-bit full subtractor cell
// Ports: x (minuend bit), y (subtrahend bit), bin (borrow in),
//        diff (difference bit), bout (borrow out).
module fsub1 (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/subr4u_serial.sv
// rtl/subr4u_serial.sv - bit-serial unsigned subtractor with add-back self-check
// Ports: clk, rst (async, active-high); in_valid/in_ready with operands a, b;
//        out_valid/out_ready with results d = (a-b) mod 2^WIDTH, borrow = (a<b),
//        chk_err = add-back mismatch flag.
module subr4u_serial
    import subr4u_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             chk_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t state, state_next;

    logic [WIDTH-1:0] sa, sb, a_orig, b_orig, res;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             cell_diff, cell_bout;
    logic             last_bit;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH:0]   addback;
    logic             chk_next;

    // The single reused cell: one bit of the subtraction per BUSY cycle.
    fsub1 u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (br),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Result fills from the MSB side, so after WIDTH shifts bit 0 is the LSB.
    assign d_next   = {cell_diff, res[WIDTH-1:1]};

    // Add the difference back to the original subtrahend; with the final borrow
    // as the top bit this must reproduce the original minuend.
    assign addback  = {1'b0, d_next} + {1'b0, b_orig};
    assign chk_next = (addback != {cell_bout, a_orig});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && in_ready) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa      <= '0;
            sb      <= '0;
            a_orig  <= '0;
            b_orig  <= '0;
            res     <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            d       <= '0;
            borrow  <= 1'b0;
            chk_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa     <= a;
                        sb     <= b;
                        a_orig <= a;
                        b_orig <= b;
                        br     <= 1'b0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    res <= d_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= cell_bout;
                    cnt <= cnt + CW'(1);
                    // Visible outputs change only when the result is complete.
                    if (last_bit) begin
                        d       <= d_next;
                        borrow  <= cell_bout;
                        chk_err <= chk_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subr4u_serial.sv
// tb/tb_subr4u_serial.sv - randomized self-checking bench for subr4u_serial
module tb_subr4u_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] d;
    logic       borrow;
    logic       chk_err;

    int vectors = 0;
    int miscompares = 0;

    subr4u_serial #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_diff(input int av, input int bv);
        int r;
        r = av - bv;
        if (r < 0) r = r + 16;
        return r[3:0];
    endfunction

    function automatic logic ref_borrow(input int av, input int bv);
        return (av < bv);
    endfunction

    // Presents one operand pair for a single cycle once the block is ready.
    // Returns at the negedge just after the accepting edge.
    task automatic send(input logic [3:0] av, input logic [3:0] bv);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts cycles until out_valid is seen; cyc=-1 when the bound expires.
    task automatic wait_out(output int cyc);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        cyc = out_valid ? n : -1;
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if ({in_ready, out_valid, d, borrow, chk_err} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%0b ov=%0b d=%0d br=%0b chk=%0b, required all 0",
                     in_ready, out_valid, d, borrow, chk_err);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %0b, required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic(input logic [3:0] av, input logic [3:0] bv);
        int cyc;
        logic [3:0] ed;
        logic       eb;
        ed = ref_diff(av, bv);
        eb = ref_borrow(av, bv);
        send(av, bv);
        wait_out(cyc);
        vectors++;
        if (cyc !== 4) begin
            miscompares++;
            $display("FAIL basic_latency %0d-%0d: got %0d cycles, required 4", av, bv, cyc);
        end
        vectors++;
        if ({d, borrow, chk_err} !== {ed, eb, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_result %0d-%0d: got d=%0d br=%0b chk=%0b, required d=%0d br=%0b chk=0",
                     av, bv, d, borrow, chk_err, ed, eb);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_consume: out_valid got %0b, required 0", out_valid);
        end
    endtask

    task automatic test_in_order;
        int cyc;
        logic [3:0] qa[$];
        logic [3:0] qb[$];
        qa = '{4'd0, 4'd15};
        qb = '{4'd1, 4'd15};
        for (int i = 0; i < 2; i++) begin
            send(qa[i], qb[i]);
            wait_out(cyc);
            vectors++;
            if (cyc < 0 || {d, borrow} !== {ref_diff(qa[i], qb[i]), ref_borrow(qa[i], qb[i])}) begin
                miscompares++;
                $display("FAIL in_order[%0d]: got cyc=%0d d=%0d br=%0b, required d=%0d br=%0b",
                         i, cyc, d, borrow, ref_diff(qa[i], qb[i]), ref_borrow(qa[i], qb[i]));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        out_ready = 1'b0;
        send(4'd12, 4'd5);
        wait_out(cyc);
        vectors++;
        if (cyc !== 4) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d, required 4", cyc);
        end
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            vectors++;
            if ({out_valid, d, borrow, in_ready} !== {1'b1, 4'd7, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got ov=%0b d=%0d br=%0b rdy=%0b, required ov=1 d=7 br=0 rdy=0",
                         i, out_valid, d, borrow, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: out_valid got %0b, required 0", out_valid);
        end
    endtask

    task automatic test_in_valid_busy;
        int n = 0;
        int cyc;
        logic [3:0] x, y, p, q;
        a = 4'd5;
        b = 4'd2;
        in_valid = 1'b1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            a = 4'($urandom);
            b = 4'($urandom);
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!out_valid || {d, borrow} !== {4'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL busy_ignore_first: got ov=%0b d=%0d br=%0b, required ov=1 d=3 br=0",
                     out_valid, d, borrow);
        end
        x = 4'($urandom);
        y = 4'($urandom);
        do begin
            p = 4'($urandom);
            q = 4'($urandom);
        end while (ref_diff(p, q) == ref_diff(x, y));
        a = x;
        b = y;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_idle_ready: got %0b, required 1", in_ready);
        end
        a = p;
        b = q;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(cyc);
        vectors++;
        if (cyc < 0 || {d, borrow} !== {ref_diff(p, q), ref_borrow(p, q)}) begin
            miscompares++;
            $display("FAIL busy_next_pair %0d-%0d: got cyc=%0d d=%0d br=%0b, required d=%0d br=%0b",
                     p, q, cyc, d, borrow, ref_diff(p, q), ref_borrow(p, q));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc;
        send(4'd7, 4'd12);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, d, borrow, in_ready} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got ov=%0b d=%0d br=%0b rdy=%0b, required all 0",
                     out_valid, d, borrow, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_pulse[%0d]: out_valid got 1, required 0", i);
            end
        end
        send(4'd8, 4'd8);
        wait_out(cyc);
        vectors++;
        if (cyc !== 4 || {d, borrow, chk_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_recover: got cyc=%0d d=%0d br=%0b chk=%0b, required cyc=4 d=0 br=0 chk=0",
                     cyc, d, borrow, chk_err);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep;
        int order[256];
        int cyc, j, t, av, bv, stall;
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            av = order[i] / 16;
            bv = order[i] % 16;
            stall = $urandom_range(0, 2);
            out_ready = (stall == 0);
            send(4'(av), 4'(bv));
            wait_out(cyc);
            vectors++;
            if (cyc !== 4 || d !== ref_diff(av, bv) || borrow !== ref_borrow(av, bv) || chk_err !== 1'b0) begin
                miscompares++;
                $display("FAIL sweep %0d-%0d: got cyc=%0d d=%0d br=%0b chk=%0b, required cyc=4 d=%0d br=%0b chk=0",
                         av, bv, cyc, d, borrow, chk_err, ref_diff(av, bv), ref_borrow(av, bv));
            end
            repeat (stall) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic(4'd9, 4'd3);
        test_basic(4'd3, 4'd9);
        test_in_order();
        test_backpressure();
        test_in_valid_busy();
        test_basic(4'd11, 4'd4);
        test_reset_mid();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/subr4u_serial.md
Name: subr4u_serial

Overview:
- Bit-serial unsigned 4-bit subtractor. It is the inverse-operation counterpart of the 4-bit unsigned adder macros in the fault-resilient arithmetic library.
- Accepts operand pairs over a valid/ready handshake and computes D = A − B LSB-first, one full-subtractor cell evaluation per clock.
- Presents the difference, the borrow-out and a self-check flag on a valid/ready output port.
- Used where area matters more than throughput, so a single 1-bit cell is reused across cycles.

Parameters:
- WIDTH, 4, operand and difference width in bits. Only 4 is verified; the RTL must still be written generically.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  minuend, unsigned
- b  input  WIDTH  subtrahend, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- d  output  WIDTH  difference (A − B) mod 2^WIDTH
- borrow  output  1  1 when A < B
- chk_err  output  1  1 when the add-back check fails

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - out_valid = 0, d = 0, borrow = 0, chk_err = 0
  - bit counter = 0, internal borrow register = 0
  - in_ready = 0 while rst is high
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a into shift register SA and b into SB, clear the borrow register, clear the counter, go to BUSY.
- BUSY (in_ready = 0, out_valid = 0), one bit per cycle, LSB first:
  - diff = SA[0] ^ SB[0] ^ br
  - br_next = (~SA[0] & SB[0]) | (~SA[0] & br) | (SB[0] & br)
  - diff shifts into the result register from the MSB side; SA and SB shift right; counter increments.
  - When the counter reaches WIDTH−1 on the current cycle, go to DONE at the next edge.
- DONE:
  - out_valid = 1; d, borrow and chk_err are stable and held.
  - On out_ready, go to IDLE; out_valid drops at that edge.
  - in_ready stays 0 in DONE, so there is no overlap between results.
- Latency:
  - Operands accepted at edge 0; bits processed at edges 1..WIDTH; out_valid high after edge WIDTH (4 cycles for WIDTH = 4).
  - Throughput: one result per WIDTH+2 cycles with out_ready tied high.
- Self-check (computed on entry to DONE, registered):
  - Add-back: {carry, sum} = d + b_orig, a (WIDTH+1)-bit add using a latched copy of b.
  - chk_err = ({carry, sum} != {borrow, a_orig}).
  - Must be 0 in fault-free operation; it exists for fault-injection campaigns.
- d and borrow update only on the transition into DONE. They hold their values through IDLE until the next result, but are qualified only by out_valid.
- in_valid during BUSY or DONE is ignored; operands are not latched and no state changes.
- Back-to-back: an in_valid arriving in the same cycle that DONE is exited is not accepted until the following cycle, when the block is in IDLE.
- Reset mid-BUSY or mid-DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse occurs.
- Wrap-around: the difference is modulo 2^WIDTH. borrow is the final br, which equals (a < b).

Decomposition:
- Package subr4u_pkg:
  - state enum type (IDLE, BUSY, DONE)
  - WIDTH default constant
  - counter width constant, clog2(WIDTH)
- Sub-module fsub1: combinational 1-bit full subtractor.
  - Inputs: x, y, bin.
  - Outputs: diff, bout.
  - Instantiated once in the datapath.
- Top level contains the FSM, the shift registers and the add-back checker.

Test Plan:
- Reset, then a=9, b=3, in_valid pulse, out_ready=1 → out_valid after exactly 4 cycles; d=6, borrow=0, chk_err=0.
- a=3, b=9 → d=10, borrow=1, chk_err=0.
- a=0, b=1 → d=15, borrow=1. Then a=15, b=15 → d=0, borrow=0. Both results delivered in order.
- Backpressure: a=12, b=5 with out_ready=0 for 6 cycles → out_valid stays high, d=7 and borrow=0 held, in_ready=0 throughout. out_valid drops one cycle after out_ready rises.
- in_valid held high with changing a/b during BUSY → only the first pair affects the result, and the next pair is accepted only in IDLE.
- Assert rst in the 2nd BUSY cycle → out_valid=0, d=0, borrow=0 asynchronously. After release, a=8, b=8 yields d=0, borrow=0 with normal latency.
- Exhaustive sweep of all 256 (a, b) pairs → d == (a−b) mod 16, borrow == (a<b), chk_err == 0 for every pair.
